// File: rtl/exu_mem_pkg.sv
// Shared definitions for the execute stage: datapath width, ALU op and
// writeback-select encodings.
package exu_mem_pkg;

  localparam int unsigned WIDTH = 32;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SLL  = 3'b001,
    ALU_SLT  = 3'b010,
    ALU_SLTU = 3'b011,
    ALU_XOR  = 3'b100,
    ALU_SR   = 3'b101,
    ALU_OR   = 3'b110,
    ALU_AND  = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_MEM = 2'b01,
    WB_PC4 = 2'b10,
    WB_IMM = 2'b11
  } wb_sel_e;

endpackage

// File: rtl/exu_alu.sv
// Combinational ALU for the execute stage. Compare-override flags take
// precedence over the op field, signed before unsigned.
module exu_alu
  import exu_mem_pkg::*;
#(
  parameter int unsigned XLEN = WIDTH
) (
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  input  logic [2:0]      i_op,
  input  logic            i_sub,
  input  logic            i_force_slt,
  input  logic            i_force_sltu,
  output logic [XLEN-1:0] o_result
);

  logic [4:0]      w_shamt;
  logic            w_lt_s;
  logic            w_lt_u;
  logic [XLEN-1:0] w_lt_s_ext;
  logic [XLEN-1:0] w_lt_u_ext;

  assign w_shamt    = i_b[4:0];
  assign w_lt_s     = $signed(i_a) < $signed(i_b);
  assign w_lt_u     = i_a < i_b;
  assign w_lt_s_ext = {{(XLEN-1){1'b0}}, w_lt_s};
  assign w_lt_u_ext = {{(XLEN-1){1'b0}}, w_lt_u};

  always_comb begin
    o_result = '0;
    if (i_force_slt) begin
      o_result = w_lt_s_ext;
    end else if (i_force_sltu) begin
      o_result = w_lt_u_ext;
    end else begin
      case (alu_op_e'(i_op))
        ALU_ADD:  o_result = i_sub ? (i_a - i_b) : (i_a + i_b);
        ALU_SLL:  o_result = i_a << w_shamt;
        ALU_SLT:  o_result = w_lt_s_ext;
        ALU_SLTU: o_result = w_lt_u_ext;
        ALU_XOR:  o_result = i_a ^ i_b;
        ALU_SR:   o_result = i_sub ? XLEN'($signed(i_a) >>> w_shamt) : (i_a >> w_shamt);
        ALU_OR:   o_result = i_a | i_b;
        ALU_AND:  o_result = i_a & i_b;
        default:  o_result = '0;
      endcase
    end
  end

endmodule

// File: rtl/exu_mem.sv
// Execute stage plus EX/MEM pipeline register with valid/ready back-pressure,
// flush, and a one-cycle registered PC redirect.
module exu_mem
  import exu_mem_pkg::*;
#(
  parameter int unsigned XLEN = WIDTH,
  parameter int unsigned WW   = 8
) (
  input  logic            sys_clk,
  input  logic            sys_rst,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic [XLEN-1:0] ex_final_a,
  input  logic [XLEN-1:0] ex_final_b,
  input  logic [2:0]      ex_alu_op,
  input  logic            ex_sub,
  input  logic            ex_slt_and_spin_off_signed,
  input  logic            ex_slt_and_spin_off_unsigned,
  input  logic            ex_is_write_dmem,
  input  logic [1:0]      ex_wb_select,
  input  logic [WW-1:0]   ex_write_width,
  input  logic [XLEN-1:0] ex_dmem_write_data,
  input  logic            ex_pc_sel,
  input  logic            flush,
  input  logic            mem_ready,
  output logic            mem_valid,
  output logic [XLEN-1:0] mem_alu_result,
  output logic            mem_is_write_dmem,
  output logic [1:0]      mem_wb_select,
  output logic [WW-1:0]   mem_write_width,
  output logic [XLEN-1:0] mem_dmem_write_data,
  output logic [XLEN-1:0] fwd_result,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_target
);

  logic [XLEN-1:0] w_alu_result;
  logic            w_accept;
  logic            w_stall;

  logic            r_valid;
  logic [XLEN-1:0] r_alu_result;
  logic            r_is_write_dmem;
  logic [1:0]      r_wb_select;
  logic [WW-1:0]   r_write_width;
  logic [XLEN-1:0] r_dmem_write_data;
  logic            r_redirect_valid;
  logic [XLEN-1:0] r_redirect_target;

  exu_alu #(.XLEN(XLEN)) u_alu (
    .i_a          (ex_final_a),
    .i_b          (ex_final_b),
    .i_op         (ex_alu_op),
    .i_sub        (ex_sub),
    .i_force_slt  (ex_slt_and_spin_off_signed),
    .i_force_sltu (ex_slt_and_spin_off_unsigned),
    .o_result     (w_alu_result)
  );

  assign w_stall  = r_valid && !mem_ready;
  assign ex_ready = !w_stall;
  assign w_accept = ex_valid && ex_ready && !flush;

  // Flush needs no explicit term: it only blocks the accept, and a held
  // entry during a stall is older than the flushed instruction.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      r_valid           <= 1'b0;
      r_alu_result      <= '0;
      r_is_write_dmem   <= 1'b0;
      r_wb_select       <= '0;
      r_write_width     <= '0;
      r_dmem_write_data <= '0;
      r_redirect_valid  <= 1'b0;
      r_redirect_target <= '0;
    end else begin
      r_redirect_valid <= w_accept && ex_pc_sel;
      if (w_accept && ex_pc_sel) begin
        r_redirect_target <= w_alu_result;
      end
      if (w_accept) begin
        r_valid           <= 1'b1;
        r_alu_result      <= w_alu_result;
        r_is_write_dmem   <= ex_is_write_dmem;
        r_wb_select       <= ex_wb_select;
        r_write_width     <= ex_write_width;
        r_dmem_write_data <= ex_dmem_write_data;
      end else if (!w_stall) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign mem_valid           = r_valid;
  assign mem_alu_result      = r_alu_result;
  assign mem_is_write_dmem   = r_is_write_dmem && r_valid;
  assign mem_wb_select       = r_wb_select;
  assign mem_write_width     = r_write_width;
  assign mem_dmem_write_data = r_dmem_write_data;
  assign fwd_result          = w_alu_result;
  assign redirect_valid      = r_redirect_valid;
  assign redirect_target     = r_redirect_target;

endmodule

// File: tb/tb_exu_mem.sv
// Directed bench for exu_mem: ALU sweep, handshake, flush, redirect, reset.
module tb_exu_mem;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_final_a;
  logic [31:0] ex_final_b;
  logic [2:0]  ex_alu_op;
  logic        ex_sub;
  logic        ex_slt_and_spin_off_signed;
  logic        ex_slt_and_spin_off_unsigned;
  logic        ex_is_write_dmem;
  logic [1:0]  ex_wb_select;
  logic [7:0]  ex_write_width;
  logic [31:0] ex_dmem_write_data;
  logic        ex_pc_sel;
  logic        flush;
  logic        mem_ready;
  logic        mem_valid;
  logic [31:0] mem_alu_result;
  logic        mem_is_write_dmem;
  logic [1:0]  mem_wb_select;
  logic [7:0]  mem_write_width;
  logic [31:0] mem_dmem_write_data;
  logic [31:0] fwd_result;
  logic        redirect_valid;
  logic [31:0] redirect_target;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic        sub;
    logic        fs;
    logic        fu;
    logic [31:0] exp;
  } alu_vec_t;

  alu_vec_t vecs [13];

  always #5 sys_clk = ~sys_clk;

  exu_mem #(.XLEN(32), .WW(8)) dut (
    .sys_clk                      (sys_clk),
    .sys_rst                      (sys_rst),
    .ex_valid                     (ex_valid),
    .ex_ready                     (ex_ready),
    .ex_final_a                   (ex_final_a),
    .ex_final_b                   (ex_final_b),
    .ex_alu_op                    (ex_alu_op),
    .ex_sub                       (ex_sub),
    .ex_slt_and_spin_off_signed   (ex_slt_and_spin_off_signed),
    .ex_slt_and_spin_off_unsigned (ex_slt_and_spin_off_unsigned),
    .ex_is_write_dmem             (ex_is_write_dmem),
    .ex_wb_select                 (ex_wb_select),
    .ex_write_width               (ex_write_width),
    .ex_dmem_write_data           (ex_dmem_write_data),
    .ex_pc_sel                    (ex_pc_sel),
    .flush                        (flush),
    .mem_ready                    (mem_ready),
    .mem_valid                    (mem_valid),
    .mem_alu_result               (mem_alu_result),
    .mem_is_write_dmem            (mem_is_write_dmem),
    .mem_wb_select                (mem_wb_select),
    .mem_write_width              (mem_write_width),
    .mem_dmem_write_data          (mem_dmem_write_data),
    .fwd_result                   (fwd_result),
    .redirect_valid               (redirect_valid),
    .redirect_target              (redirect_target)
  );

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic set_add(input logic [31:0] a, input logic [31:0] b);
    ex_final_a = a;
    ex_final_b = b;
    ex_alu_op  = 3'b000;
    ex_sub     = 1'b0;
    ex_slt_and_spin_off_signed   = 1'b0;
    ex_slt_and_spin_off_unsigned = 1'b0;
  endtask

  task automatic test_reset();
    sys_rst = 1'b0; ex_valid = 1'b0; flush = 1'b0; mem_ready = 1'b1;
    ex_pc_sel = 1'b0; ex_is_write_dmem = 1'b0; ex_wb_select = 2'b00;
    ex_write_width = 8'h00; ex_dmem_write_data = 32'h0;
    set_add(32'h0, 32'h0);
    #2;
    n_total++;
    if (mem_valid !== 1'b0 || redirect_valid !== 1'b0 || mem_alu_result !== 32'h0 ||
        mem_is_write_dmem !== 1'b0 || mem_dmem_write_data !== 32'h0 || redirect_target !== 32'h0)
      $display("FAIL reset_state: valid=%b redir=%b res=%h wr=%b sd=%h tgt=%h, want all zero",
               mem_valid, redirect_valid, mem_alu_result, mem_is_write_dmem,
               mem_dmem_write_data, redirect_target);
    else n_pass++;
    n_total++;
    if (ex_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", ex_ready);
    else n_pass++;
    step(); step();
    sys_rst = 1'b1;
    step();
  endtask

  task automatic test_alu();
    vecs = '{
      '{32'hFFFFFFFF, 32'h1,  3'b000, 1'b0, 1'b0, 1'b0, 32'h00000000},
      '{32'hFFFFFFFF, 32'h1,  3'b000, 1'b1, 1'b0, 1'b0, 32'hFFFFFFFE},
      '{32'h80000000, 32'h4,  3'b101, 1'b1, 1'b0, 1'b0, 32'hF8000000},
      '{32'h80000000, 32'h4,  3'b101, 1'b0, 1'b0, 1'b0, 32'h08000000},
      '{32'h00000001, 32'h24, 3'b001, 1'b0, 1'b0, 1'b0, 32'h00000010},
      '{32'hFFFFFFFF, 32'h1,  3'b000, 1'b0, 1'b0, 1'b1, 32'h00000000},
      '{32'hFFFFFFFF, 32'h1,  3'b000, 1'b0, 1'b1, 1'b0, 32'h00000001},
      '{32'hFFFFFFFF, 32'h1,  3'b100, 1'b0, 1'b1, 1'b1, 32'h00000001},
      '{32'hFFFFFFFF, 32'h1,  3'b010, 1'b0, 1'b0, 1'b0, 32'h00000001},
      '{32'hFFFFFFFF, 32'h1,  3'b011, 1'b0, 1'b0, 1'b0, 32'h00000000},
      '{32'h0000F0F0, 32'hFF00, 3'b100, 1'b0, 1'b0, 1'b0, 32'h00000FF0},
      '{32'h0000F0F0, 32'hFF00, 3'b110, 1'b0, 1'b0, 1'b0, 32'h0000FFF0},
      '{32'h0000F0F0, 32'hFF00, 3'b111, 1'b0, 1'b0, 1'b0, 32'h0000F000}
    };
    ex_valid = 1'b0;
    for (int i = 0; i < 13; i++) begin
      ex_final_a = vecs[i].a;
      ex_final_b = vecs[i].b;
      ex_alu_op  = vecs[i].op;
      ex_sub     = vecs[i].sub;
      ex_slt_and_spin_off_signed   = vecs[i].fs;
      ex_slt_and_spin_off_unsigned = vecs[i].fu;
      #1;
      n_total++;
      if (fwd_result !== vecs[i].exp)
        $display("FAIL alu_vec%0d: got %h want %h", i, fwd_result, vecs[i].exp);
      else n_pass++;
    end
    set_add(32'h0, 32'h0);
  endtask

  task automatic test_stall();
    mem_ready = 1'b1; ex_valid = 1'b1;
    set_add(32'd5, 32'd3);
    ex_is_write_dmem = 1'b1; ex_wb_select = 2'b01; ex_write_width = 8'h0F;
    ex_dmem_write_data = 32'hCAFE0001;
    step();
    n_total++;
    if (mem_valid !== 1'b1 || mem_alu_result !== 32'd8 || mem_is_write_dmem !== 1'b1 ||
        mem_wb_select !== 2'b01 || mem_write_width !== 8'h0F || mem_dmem_write_data !== 32'hCAFE0001)
      $display("FAIL stall_load: valid=%b res=%h wr=%b wb=%b ww=%h sd=%h, want 1 8 1 01 0f cafe0001",
               mem_valid, mem_alu_result, mem_is_write_dmem, mem_wb_select,
               mem_write_width, mem_dmem_write_data);
    else n_pass++;
    mem_ready = 1'b0;
    set_add(32'd100, 32'd1);
    ex_is_write_dmem = 1'b0; ex_wb_select = 2'b10; ex_write_width = 8'h01;
    ex_dmem_write_data = 32'h12345678;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_total++;
      if (ex_ready !== 1'b0) $display("FAIL stall_ready%0d: got %b want 0", c, ex_ready);
      else n_pass++;
      step();
      n_total++;
      if (mem_valid !== 1'b1 || mem_alu_result !== 32'd8 || mem_is_write_dmem !== 1'b1 ||
          mem_wb_select !== 2'b01 || mem_write_width !== 8'h0F || mem_dmem_write_data !== 32'hCAFE0001)
        $display("FAIL stall_hold%0d: valid=%b res=%h wr=%b wb=%b ww=%h sd=%h, want 1 8 1 01 0f cafe0001",
                 c, mem_valid, mem_alu_result, mem_is_write_dmem, mem_wb_select,
                 mem_write_width, mem_dmem_write_data);
      else n_pass++;
    end
    mem_ready = 1'b1;
    #1;
    n_total++;
    if (ex_ready !== 1'b1) $display("FAIL stall_release_ready: got %b want 1", ex_ready);
    else n_pass++;
    step();
    n_total++;
    if (mem_valid !== 1'b1 || mem_alu_result !== 32'd101 || mem_wb_select !== 2'b10)
      $display("FAIL stall_release: valid=%b res=%h wb=%b, want 1 00000065 10",
               mem_valid, mem_alu_result, mem_wb_select);
    else n_pass++;
    ex_valid = 1'b0; ex_is_write_dmem = 1'b1;
    step();
    n_total++;
    if (mem_valid !== 1'b0 || mem_is_write_dmem !== 1'b0)
      $display("FAIL drain: valid=%b wr=%b, want 0 0", mem_valid, mem_is_write_dmem);
    else n_pass++;
    ex_is_write_dmem = 1'b0;
  endtask

  task automatic test_back_to_back();
    mem_ready = 1'b1; ex_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      set_add(32'(i * 10), 32'(i));
      step();
      n_total++;
      if (mem_valid !== 1'b1 || mem_alu_result !== 32'(i * 11))
        $display("FAIL b2b%0d: valid=%b res=%0d, want 1 %0d", i, mem_valid, mem_alu_result, i * 11);
      else n_pass++;
    end
    ex_valid = 1'b0;
    step();
  endtask

  task automatic test_flush();
    mem_ready = 1'b1; ex_valid = 1'b1;
    set_add(32'd1, 32'd1);
    step();
    flush = 1'b1; ex_pc_sel = 1'b1;
    set_add(32'd40, 32'd2);
    step();
    n_total++;
    if (mem_valid !== 1'b0 || redirect_valid !== 1'b0)
      $display("FAIL flush_kill: valid=%b redir=%b, want 0 0", mem_valid, redirect_valid);
    else n_pass++;
    flush = 1'b0; ex_pc_sel = 1'b0;
    set_add(32'd7, 32'd2);
    step();
    mem_ready = 1'b0; flush = 1'b1; ex_pc_sel = 1'b1;
    set_add(32'd50, 32'd50);
    step(); step();
    n_total++;
    if (mem_valid !== 1'b1 || mem_alu_result !== 32'd9 || redirect_valid !== 1'b0)
      $display("FAIL flush_stall_hold: valid=%b res=%h redir=%b, want 1 9 0",
               mem_valid, mem_alu_result, redirect_valid);
    else n_pass++;
    flush = 1'b0; ex_pc_sel = 1'b0; ex_valid = 1'b0; mem_ready = 1'b1;
    step();
  endtask

  task automatic test_redirect();
    int unsigned pulses;
    mem_ready = 1'b1; ex_valid = 1'b1; ex_pc_sel = 1'b1;
    set_add(32'h1000, 32'h20);
    step();
    n_total++;
    if (redirect_valid !== 1'b1 || redirect_target !== 32'h1020)
      $display("FAIL redirect_pulse: valid=%b tgt=%h, want 1 00001020", redirect_valid, redirect_target);
    else n_pass++;
    ex_valid = 1'b0; ex_pc_sel = 1'b0;
    step();
    n_total++;
    if (redirect_valid !== 1'b0) $display("FAIL redirect_one_cycle: got %b want 0", redirect_valid);
    else n_pass++;
    ex_valid = 1'b1;
    set_add(32'd3, 32'd4);
    step();
    mem_ready = 1'b0; ex_pc_sel = 1'b1;
    set_add(32'h2000, 32'h4);
    pulses = 0;
    for (int c = 0; c < 2; c++) begin
      step();
      pulses += redirect_valid;
    end
    mem_ready = 1'b1;
    step();
    pulses += redirect_valid;
    n_total++;
    if (redirect_target !== 32'h2004)
      $display("FAIL redirect_stalled_tgt: got %h want 00002004", redirect_target);
    else n_pass++;
    ex_valid = 1'b0; ex_pc_sel = 1'b0;
    for (int c = 0; c < 2; c++) begin
      step();
      pulses += redirect_valid;
    end
    n_total++;
    if (pulses !== 1) $display("FAIL redirect_stalled_count: got %0d want 1", pulses);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    mem_ready = 1'b1; ex_valid = 1'b1; ex_pc_sel = 1'b1;
    set_add(32'h11, 32'h22);
    step();
    n_total++;
    if (mem_valid !== 1'b1 || redirect_valid !== 1'b1)
      $display("FAIL reset_mid_pre: valid=%b redir=%b, want 1 1", mem_valid, redirect_valid);
    else n_pass++;
    #2;
    sys_rst = 1'b0;
    #1;
    n_total++;
    if (mem_valid !== 1'b0 || redirect_valid !== 1'b0 || mem_alu_result !== 32'h0)
      $display("FAIL reset_mid: valid=%b redir=%b res=%h, want 0 0 0",
               mem_valid, redirect_valid, mem_alu_result);
    else n_pass++;
    ex_valid = 1'b0; ex_pc_sel = 1'b0;
    step();
    sys_rst = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_alu();
    test_stall();
    test_back_to_back();
    test_flush();
    test_redirect();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
